// File: rtl/library_load.sv
// library_load: replays one stored stroke from the 26-slot point library.
// Reads {4'b0, slot, index} from a fixed-latency memory port, buffers the
// returned points in a small first-word-fall-through FIFO, and presents them
// downstream on a valid/ready stream.
//
// Ports:
//   i_clk, i_rst_n        clock / asynchronous active-low reset
//   i_start, i_slot, i_len replay request (sampled only in IDLE)
//   i_abort               synchronous abort of a replay in progress
//   o_rd_en, o_addr       memory read strobe and address
//   i_rd_data             read data {x[4:0], y[4:0]}, RD_LAT cycles after o_rd_en
//   o_valid, i_ready      output point handshake; o_x / o_y are 0 when !o_valid
//   o_busy                high while reading or draining
//   o_done                one-cycle pulse after the last point is accepted
//   o_err                 one-cycle pulse when a start names slot >= 26
module library_load #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [4:0]  i_slot,
  input  logic [10:0] i_len,
  input  logic        i_abort,
  output logic        o_rd_en,
  output logic [19:0] o_addr,
  input  logic [9:0]  i_rd_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [4:0]  o_x,
  output logic [4:0]  o_y,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state;
  logic [4:0]          slot_r;
  logic [10:0]         len_r;
  logic [10:0]         idx_r;
  logic [11:0]         recv_r;
  logic [RD_LAT-1:0]   inflight_sr;
  logic [RD_LAT-1:0]   sr_next;
  logic [9:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         fifo_count;
  logic [15:0]         inflight_cnt;
  logic [15:0]         credit_used;
  logic [9:0]          head;
  logic                rd_issue;
  logic                fifo_push;
  logic                fifo_pop;
  logic                last_pop;
  logic                abort_act;

  always_comb begin
    inflight_cnt = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + 16'(inflight_sr[i]);
    end
    // Credit counts both buffered points and reads still in the memory pipe,
    // so the FIFO can never overflow regardless of downstream stalls.
    credit_used = 16'(fifo_count) + inflight_cnt;
    rd_issue    = (state == READ) && (idx_r < len_r) &&
                  (credit_used < 16'(FIFO_DEPTH));
    o_rd_en     = rd_issue;
    o_addr      = rd_issue ? {4'b0, slot_r, idx_r} : '0;

    o_valid     = (fifo_count != '0);
    head        = fifo_mem[rd_ptr];
    o_x         = o_valid ? head[9:5] : '0;
    o_y         = o_valid ? head[4:0] : '0;
    o_busy      = (state != IDLE);

    fifo_pop    = o_valid && i_ready;
    fifo_push   = inflight_sr[RD_LAT-1];
    // Shift in the new issue at bit 0; the top bit marks a return this cycle.
    sr_next     = RD_LAT'({inflight_sr, rd_issue});
    last_pop    = fifo_pop && ((recv_r + 12'd1) == {1'b0, len_r});
    abort_act   = i_abort && (state != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (fifo_push && !abort_act) begin
      fifo_mem[wr_ptr] <= i_rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      slot_r      <= '0;
      len_r       <= '0;
      idx_r       <= '0;
      recv_r      <= '0;
      inflight_sr <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (abort_act) begin
        // Flush everything; clearing the shift register drops late returns.
        state       <= IDLE;
        inflight_sr <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fifo_count  <= '0;
      end else begin
        inflight_sr <= sr_next;
        if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
        if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);
        if (fifo_pop)  recv_r <= recv_r + 12'd1;

        case (state)
          IDLE: begin
            if (i_start && !i_abort) begin
              if (i_slot < 5'd26) begin
                state  <= READ;
                slot_r <= i_slot;
                len_r  <= i_len;
                idx_r  <= '0;
                recv_r <= '0;
              end else begin
                o_err <= 1'b1;
              end
            end
          end
          READ: begin
            if (len_r == '0) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end else if (rd_issue) begin
              idx_r <= idx_r + 11'd1;
              if ((idx_r + 11'd1) == len_r) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (last_pop) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
